// File: rtl/if_id_register.sv
`default_nettype none
// ============================================================================
// Module   : if_id_register
// Brief    : IF/ID pipeline register with a two-entry ready/valid skid buffer,
//            field slicing and immediate-extension classification.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_register #(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      out_rs,
  output logic [4:0]      out_rt,
  output logic [4:0]      out_rd,
  output logic [15:0]     out_imm16,
  output logic [1:0]      out_imm_kind,
  output logic            out_illegal
);

  localparam logic [1:0] c_KIND_NONE  = 2'd0;
  localparam logic [1:0] c_KIND_SIGN  = 2'd1;
  localparam logic [1:0] c_KIND_ZERO  = 2'd2;
  localparam logic [1:0] c_KIND_UPPER = 2'd3;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
    logic [1:0]      kind;
    logic            illegal;
  } entry_t;

  state_t r_state;
  entry_t r_main;
  entry_t r_skid;
  entry_t w_in;
  logic   w_accept;
  logic   w_emit;

  // Decode the incoming word so that the stored entry already carries its class.
  always_comb begin
    w_in.instr   = in_instr;
    w_in.pc      = in_pc;
    w_in.kind    = c_KIND_NONE;
    w_in.illegal = 1'b0;
    case (in_instr[31:26])
      6'h0F:                      w_in.kind = c_KIND_UPPER;
      6'h0C, 6'h0D, 6'h0E:        w_in.kind = c_KIND_ZERO;
      6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h23, 6'h2B, 6'h04, 6'h05: w_in.kind = c_KIND_SIGN;
      6'h00, 6'h02, 6'h03:        w_in.kind = c_KIND_NONE;
      default:                    w_in.illegal = 1'b1;
    endcase
  end

  assign in_ready  = (r_state != S_TWO) && !rst;
  assign out_valid = (r_state != S_EMPTY);
  assign w_accept  = in_valid && in_ready;
  assign w_emit    = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else if (flush) begin
      // Only occupancy is cleared; an emit this cycle has already been consumed.
      r_state <= S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_main  <= w_in;
            r_state <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_accept && w_emit) begin
            r_main <= w_in;
          end else if (w_accept) begin
            r_skid  <= w_in;
            r_state <= S_TWO;
          end else if (w_emit) begin
            r_state <= S_EMPTY;
          end
        end
        S_TWO: begin
          if (w_emit) begin
            r_main  <= r_skid;
            r_state <= S_ONE;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  assign out_instr    = r_main.instr;
  assign out_pc       = r_main.pc;
  assign out_rs       = r_main.instr[25:21];
  assign out_rt       = r_main.instr[20:16];
  assign out_rd       = r_main.instr[15:11];
  assign out_imm16    = r_main.instr[15:0];
  assign out_imm_kind = r_main.kind;
  assign out_illegal  = r_main.illegal;

endmodule
`default_nettype wire

// File: doc/if_id_register.md
Name: if_id_register

Overview:
- Fetch/decode pipeline register with a ready/valid skid buffer for the single-cycle/pipelined MIPS datapath.
- Latches the fetched instruction and its PC, and slices the rs, rt, rd and imm16 fields.
- Classifies the immediate extension kind. The registered imm16 and kind drive the sign, zero and lower-zero (LUI) extenders directly.
- Absorbs one cycle of downstream stall without dropping an instruction. Supports a branch flush.

Parameters:
- PC_W, 32, width of the PC carried alongside the instruction.

Ports:
- clk  input  1  clock
- rst  input  1  reset; one clock; reset is synchronous and active-high
- flush  input  1  discard all held instructions (taken branch or jump)
- in_valid  input  1  fetch presents an instruction
- in_ready  output  1  stage can accept
- in_instr  input  32  instruction word
- in_pc  input  PC_W  PC of in_instr
- out_valid  output  1  decoded instruction available
- out_ready  input  1  downstream consumes
- out_instr  output  32  registered instruction
- out_pc  output  PC_W  registered PC
- out_rs  output  5  instr[25:21]
- out_rt  output  5  instr[20:16]
- out_rd  output  5  instr[15:11]
- out_imm16  output  16  instr[15:0]; feeds the extenders' 16-bit input
- out_imm_kind  output  2  0 none, 1 sign, 2 zero, 3 upper (LUI)
- out_illegal  output  1  opcode not recognised

Behaviour:
- Handshakes: accept = in_valid && in_ready; emit = out_valid && out_ready.
- Storage: main register (drives all outputs) and skid register, each with a valid bit.
- Decode is computed on the incoming word before it is stored, so every output is a flop. Latency in→out is 1 cycle.
- States:
  - EMPTY: nothing held.
  - ONE: main valid.
  - TWO: main and skid valid.
- Signal rules:
  - in_ready = (state != TWO) && !rst.
  - out_valid = (state != EMPTY).
- Transitions (flush and rst have priority over all of these):
  - EMPTY: accept → ONE, main loaded.
  - ONE, accept && emit → ONE, main reloaded with the incoming word.
  - ONE, accept && !emit → TWO, skid loaded.
  - ONE, !accept && emit → EMPTY.
  - ONE, neither → hold.
  - TWO: emit → ONE, main ← skid. Otherwise hold. No accept is possible in TWO.
- Stall: while out_valid && !out_ready, all out_* are held bit-stable.
- Flush:
  - Next state is EMPTY; both valids are cleared.
  - A word accepted in the same cycle is dropped.
  - An emit in the same cycle still completes; the downstream consumed it.
  - Data flops may retain stale values; only the valids are cleared.
- Reset:
  - state EMPTY, out_valid 0, in_ready 0 while rst is high and 1 in the first cycle after.
  - out_instr, out_pc, out_rs, out_rt, out_rd, out_imm16 reset to 0; out_imm_kind 0; out_illegal 0.
  - Reset mid-operation discards held words identically to flush.
- Decode on opcode instr[31:26]:
  - 0x0F LUI → 3.
  - 0x0C, 0x0D, 0x0E (ANDI/ORI/XORI) → 2.
  - 0x08–0x0B, 0x23, 0x2B, 0x04, 0x05 → 1.
  - 0x00, 0x02, 0x03 → 0.
  - Any other opcode → kind 0, out_illegal 1.
- Field slicing applies regardless of instruction format. Downstream decides which fields are meaningful.
- Order: instructions are emitted in acceptance order. No duplication, no loss except by flush/rst.
- PC is carried unmodified, PC_W bits. No arithmetic in this block.

Test Plan:
- Reset then single LUI: in_instr=0x3C081234, pc=0x00400000, out_ready=1 → next cycle out_valid=1, out_rt=8, out_imm16=0x1234, out_imm_kind=3, out_illegal=0. One cycle later out_valid=0.
- Back-to-back streaming: LUI 0x3C081234, ORI 0x35085678, ADDI 0x2009FFFF, one per cycle, out_ready=1 → three consecutive emits in order. Kinds 3, 2, 1; imm16 0x1234, 0x5678, 0xFFFF; in_ready stays 1.
- Stall/skid: out_ready=0 while feeding R-type 0x01095020 then LUI 0x3C081234 → state TWO, in_ready=0, outputs stable with rs=8, rt=9, rd=10, kind 0. Raise out_ready → R-type emitted, then LUI emitted; in_ready returns to 1 one cycle after the first emit.
- Flush with full buffer: state TWO, assert flush for 1 cycle with in_valid=1 → out_valid=0 and in_ready=1 next cycle. Neither held word nor the offered word ever appears.
- Illegal opcode: in_instr=0xFC000000 → out_illegal=1, out_imm_kind=0, out_valid=1. The following legal ORI clears out_illegal.
- Reset mid-stall: state TWO, rst high for 1 cycle → out_valid=0 and all outputs 0 during the reset cycle. in_ready=0 during rst and 1 the cycle after.
